countdown_timer_gen: RTL
========================

Name: countdown_timer_gen

Overview:
Parametrised synchronous countdown/count-up timer for the watch datapath, with BCD mm:ss digits driven straight into the display mux. It replaces edge-triggered button logic with single-clock pulse inputs and an internal 1 Hz prescaler. It adds pause/resume, clear, configurable minute range, a count-up (stopwatch) mode and a timed expiry alarm.

Parameters:
TICK_DIV, 100000000, clk100MHz cycles per 1-second tick (>=2)
MAX_MIN, 99, highest minute value, 1..99
ALARM_SECS, 10, ticks the alarm stays high after expiry (>=1)

Ports:
clk100MHz  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
en_sel  in  1  timer mode selected on the display; when low, start_stop and *_inc are ignored
sec_inc  in  1  single-cycle pulse: +1 s
tensec_inc  in  1  single-cycle pulse: +10 s
min_inc  in  1  single-cycle pulse: +1 min
start_stop  in  1  single-cycle pulse: start/pause/resume/acknowledge
clear  in  1  single-cycle pulse: return to IDLE with 00:00; honoured regardless of en_sel
count_up  in  1  0 = countdown, 1 = count-up; sampled only on the IDLE->RUN transition
tenmin  out  4  BCD tens of minutes
onemin  out  4  BCD units of minutes
tensec  out  4  BCD tens of seconds (0..5)
onesec  out  4  BCD units of seconds
running  out  1  high in RUN
alarm  out  1  high in EXPIRED

Behaviour:
- Reset: state IDLE, all digits 0, running 0, alarm 0, prescaler 0, latched mode 0.
- All outputs are registered. An effect appears on the outputs one cycle after the clock edge that samples the event.
- Priority per cycle: reset > clear > start_stop > increments. Of simultaneous increments, only one is applied: min_inc, then tensec_inc, then sec_inc.
- Prescaler: counts 0..TICK_DIV-1 in RUN and EXPIRED and holds in IDLE/PAUSE. It is zeroed on every entry to RUN or EXPIRED. tick = (prescaler == TICK_DIV-1).
- Value V = minutes*60 + seconds, range 0..MAX_MIN*60+59. Digits are always valid BCD.
- Increments are accepted only in IDLE and PAUSE with en_sel=1; they are ignored in RUN and EXPIRED.
  - Seconds carry into minutes.
  - Minutes wrap modulo MAX_MIN+1; seconds are kept (e.g. MAX_MIN=12: 12:50 + tensec_inc -> 00:00; 12:30 + min_inc -> 00:30).
- States:
  - IDLE:
    - start_stop with count_up=0 and V!=0 -> RUN (mode latched).
    - start_stop with count_up=1 -> RUN from any V.
    - start_stop with count_up=0 and V=0 is ignored.
  - RUN:
    - On tick, countdown decrements V with borrow (01:00 -> 00:59). On the tick that makes V=0, go to EXPIRED.
    - On tick, count-up increments V. On the tick that makes V=MAX_MIN:59, go to EXPIRED.
    - start_stop -> PAUSE. If a tick lands on the same cycle, the tick update is applied first.
  - PAUSE: digits hold; start_stop -> RUN (prescaler zeroed).
  - EXPIRED:
    - alarm=1; digits hold the terminal value.
    - After ALARM_SECS ticks, go to IDLE (alarm 0, digits kept).
    - start_stop (with en_sel) or clear -> IDLE immediately.
- clear in any state -> IDLE, digits 00:00, alarm 0, prescaler 0.
- reset asserted mid-operation zeroes outputs asynchronously. After release, the block starts from IDLE with no pending tick.

Test Plan:
1. TICK_DIV=4, MAX_MIN=12: min_inc x1, sec_inc x5 -> 01:05; start_stop -> running=1; after 6 ticks (24 cycles) -> 00:59, running still 1.
2. Preset 00:02, start_stop -> alarm=1 one cycle after the 2nd tick (digits 00:00); ALARM_SECS=3 -> alarm drops after 12 more cycles, state IDLE; a second run acknowledged by start_stop during EXPIRED drops alarm in 1 cycle.
3. MAX_MIN=12: min_inc x13 from 00:00 -> 00:00; preset 12:50 + tensec_inc -> 00:00; sec_inc and min_inc on the same cycle -> only minutes change; en_sel=0 -> all inc/start ignored.
4. Running 00:10: start_stop -> PAUSE, digits frozen for 40 cycles, sec_inc -> 00:10 becomes 00:11 only in PAUSE (ignored during RUN); start_stop resumes, next change after exactly TICK_DIV cycles.
5. count_up=1, preset 12:57, start -> 12:58, 12:59 then alarm=1; count_up toggled mid-RUN has no effect; countdown start at 00:00 ignored.
6. Assert reset mid-RUN between clock edges -> all digits 0, running 0, alarm 0 immediately; clear during EXPIRED -> 00:00, IDLE next cycle.

Source files
------------

// File: rtl/countdown_timer_gen.sv
// countdown_timer_gen
//   Countdown / count-up mm:ss timer with an internal 1 Hz prescaler,
//   pause/resume, clear, configurable minute range and a timed expiry alarm.
//   The four BCD digit registers are the timer value itself; arithmetic is
//   done on a binary view of them and written back as BCD.
// Ports
//   clk100MHz                      system clock, rising edge
//   reset                          async active-high reset
//   en_sel                         gates start_stop and the *_inc pulses
//   sec_inc/tensec_inc/min_inc     single-cycle preset pulses
//   start_stop                     start / pause / resume / alarm acknowledge
//   clear                          back to IDLE with 00:00 (not gated)
//   count_up                       mode, latched on IDLE->RUN
//   tenmin/onemin/tensec/onesec    BCD digits (registered)
//   running, alarm                 registered state flags
module countdown_timer_gen #(
  parameter int TICK_DIV   = 100000000,
  parameter int MAX_MIN    = 99,
  parameter int ALARM_SECS = 10
) (
  input  logic       clk100MHz,
  input  logic       reset,
  input  logic       en_sel,
  input  logic       sec_inc,
  input  logic       tensec_inc,
  input  logic       min_inc,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       count_up,
  output logic [3:0] tenmin,
  output logic [3:0] onemin,
  output logic [3:0] tensec,
  output logic [3:0] onesec,
  output logic       running,
  output logic       alarm
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(ALARM_SECS + 1);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] AMAX = AW'(ALARM_SECS - 1);
  localparam logic [6:0]    MMAX = 7'(MAX_MIN);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [AW-1:0] acnt;
  logic          mode;   // 1 = count-up

  logic          tick, ss, any_inc, val_nz;
  logic [6:0]    cur_min, im, dm, um;
  logic [5:0]    cur_sec, is, ds, us;
  logic [15:0]   inc_val, tick_val;
  logic          tick_term;

  function automatic logic [15:0] to_bcd(input logic [6:0] m, input logic [5:0] s);
    logic [6:0] mt, mo;
    logic [5:0] st, so;
    mt = m / 7'd10;
    mo = m % 7'd10;
    st = s / 6'd10;
    so = s % 6'd10;
    return {mt[3:0], mo[3:0], st[3:0], so[3:0]};
  endfunction

  function automatic logic [6:0] min_wrap(input logic [6:0] m);
    return (m == MMAX) ? 7'd0 : m + 7'd1;
  endfunction

  assign cur_min = 7'(tenmin) * 7'd10 + 7'(onemin);
  assign cur_sec = 6'(tensec) * 6'd10 + 6'(onesec);
  assign tick    = (presc == PMAX);
  assign ss      = en_sel & start_stop;
  assign any_inc = en_sel & (sec_inc | tensec_inc | min_inc);
  assign val_nz  = |{tenmin, onemin, tensec, onesec};

  // Value datapath: preset increment, countdown step, count-up step.
  always_comb begin
    im = cur_min;
    is = cur_sec;
    if (min_inc) begin
      im = min_wrap(cur_min);
    end else if (tensec_inc) begin
      if (cur_sec >= 6'd50) begin
        is = cur_sec - 6'd50;
        im = min_wrap(cur_min);
      end else begin
        is = cur_sec + 6'd10;
      end
    end else if (sec_inc) begin
      if (cur_sec == 6'd59) begin
        is = 6'd0;
        im = min_wrap(cur_min);
      end else begin
        is = cur_sec + 6'd1;
      end
    end
    inc_val = to_bcd(im, is);

    // Countdown from 00:00 (only reachable by presetting in PAUSE) wraps
    // to the top of the range rather than sticking.
    dm = cur_min;
    ds = cur_sec - 6'd1;
    if (cur_sec == 6'd0) begin
      ds = 6'd59;
      dm = (cur_min == 7'd0) ? MMAX : cur_min - 7'd1;
    end

    um = cur_min;
    us = cur_sec + 6'd1;
    if (cur_sec == 6'd59) begin
      us = 6'd0;
      um = min_wrap(cur_min);
    end

    tick_val  = mode ? to_bcd(um, us) : to_bcd(dm, ds);
    // Terminal is judged on the value this tick produces.
    tick_term = mode ? (cur_min == MMAX && cur_sec == 6'd58)
                     : (cur_min == 7'd0 && cur_sec == 6'd1);
  end

  always_ff @(posedge clk100MHz or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      {tenmin, onemin, tensec, onesec} <= '0;
      presc   <= '0;
      acnt    <= '0;
      mode    <= 1'b0;
      running <= 1'b0;
      alarm   <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      {tenmin, onemin, tensec, onesec} <= '0;
      presc   <= '0;
      acnt    <= '0;
      running <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      if (state == RUN || state == EXPIRED)
        presc <= tick ? '0 : presc + PW'(1);
      case (state)
        IDLE: begin
          // A start_stop pulse takes the cycle even when it is refused,
          // so simultaneous increments are dropped.
          if (ss) begin
            if (count_up || val_nz) begin
              state   <= RUN;
              mode    <= count_up;
              presc   <= '0;
              running <= 1'b1;
            end
          end else if (any_inc) begin
            {tenmin, onemin, tensec, onesec} <= inc_val;
          end
        end
        RUN: begin
          if (tick) begin
            {tenmin, onemin, tensec, onesec} <= tick_val;
            // A terminal tick beats a coincident pause request.
            if (tick_term) begin
              state   <= EXPIRED;
              presc   <= '0;
              acnt    <= '0;
              running <= 1'b0;
              alarm   <= 1'b1;
            end else if (ss) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
          end else if (ss) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        end
        PAUSE: begin
          if (ss) begin
            state   <= RUN;
            presc   <= '0;
            running <= 1'b1;
          end else if (any_inc) begin
            {tenmin, onemin, tensec, onesec} <= inc_val;
          end
        end
        EXPIRED: begin
          if (ss) begin
            state <= IDLE;
            alarm <= 1'b0;
          end else if (tick) begin
            if (acnt == AMAX) begin
              state <= IDLE;
              acnt  <= '0;
              alarm <= 1'b0;
            end else begin
              acnt <= acnt + AW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
